// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: ALU control codes, the
// ALUop encodings used by the upstream ALU control decoder, and the
// execute-stage FSM state encoding.
package alu_pkg;

  // 3-bit ALU control codes produced by the ALU control decoder.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUop encodings driven by the main decoder into the ALU control decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // EXEC is the cycle in which done is high; MUL covers the multiplier steps.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10
  } state_t;

  // Signed overflow of an add, given the sign bits of a, b and the sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// LSB first, WIDTH steps after load. finish is high during the last step and
// product presents the completed 2*WIDTH-bit product in that same cycle.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               finish,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt;
  logic               active;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit (acc[0]) is set, then shift the whole thing right.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc[WIDTH-1:1]};
    finish   = active && (cnt == CW'(WIDTH - 1));
    product  = acc_step;
  end

  // Accumulator, step counter and activity flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      acc     <= '0;
      mcand_q <= '0;
      cnt     <= '0;
      active  <= 1'b0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, mplier};
      mcand_q <= mcand;
      cnt     <= '0;
      active  <= 1'b1;
    end else if (active) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
      if (finish) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle add/sub/and/or/slt with registered result
// and flags, plus an optional iterative multiplier on code 3'b011 built only
// when ALU_MUL_EN is defined. Without ALU_MUL_EN, 3'b011 is illegal and busy
// is constantly 0.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int M = WIDTH - 1;

  state_t           state, state_next;
  logic             accept;
  logic             is_mul;
  logic             mul_load;
  logic [WIDTH-1:0] sum, diff, res_c;
  logic             sub_ovf, ovf_c, ill_c;

`ifdef ALU_MUL_EN
  logic               mul_finish;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .mcand   (op_a),
    .mplier  (op_b),
    .finish  (mul_finish),
    .product (mul_product)
  );
`endif

  // Single-cycle datapath: result and flags for the code presented with start.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and infers a latch.
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    sub_ovf = (op_a[M] != op_b[M]) && (diff[M] != op_a[M]);
    res_c   = '0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    is_mul  = 1'b0;
    case (alu_ctl)
      ALU_ADD: begin
        res_c = sum;
        ovf_c = add_ovf(op_a[M], op_b[M], sum[M]);
      end
      ALU_SUB: begin
        res_c = diff;
        ovf_c = sub_ovf;
      end
      ALU_AND: res_c = op_a & op_b;
      ALU_OR:  res_c = op_a | op_b;
      ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, diff[M] ^ sub_ovf};
`ifdef ALU_MUL_EN
      ALU_MUL: is_mul = 1'b1;
`endif
      default: ill_c = 1'b1;
    endcase
  end

  // A new request is taken whenever the multiplier is not running, including
  // the done cycle, which gives back-to-back single-cycle throughput.
  assign accept = start && (state != ST_MUL);

  // Next-state logic and multiplier load strobe.
  always_comb begin
    state_next = state;
    mul_load   = 1'b0;
    case (state)
      ST_IDLE, ST_EXEC: begin
        if (start) begin
          state_next = is_mul ? ST_MUL : ST_EXEC;
          mul_load   = is_mul;
        end else begin
          state_next = ST_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      ST_MUL: if (mul_finish) state_next = ST_EXEC;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Result and flag registers; they only change when an operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !is_mul) begin
      result   <= res_c;
      zero     <= (res_c == '0);
      overflow <= ovf_c;
      illegal  <= ill_c;
    end
`ifdef ALU_MUL_EN
    else if (state == ST_MUL && mul_finish) begin
      result   <= mul_product[WIDTH-1:0];
      zero     <= (mul_product[WIDTH-1:0] == '0);
      overflow <= |mul_product[2*WIDTH-1:WIDTH];
      illegal  <= 1'b0;
    end
`endif
  end

  assign done = (state == ST_EXEC);
`ifdef ALU_MUL_EN
  assign busy = (state == ST_MUL);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed requests push their expected
// response and done cycle; a monitor checks every done pulse against the queue.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk, rst, start;
  logic [2:0]   alu_ctl;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, zero, overflow, illegal;
  logic [W-1:0] result;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         ill;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_pass;
  int   n_total;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctl  (alu_ctl),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .illegal  (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Drive one request at the falling edge; push its response when one is due.
  task automatic issue(input logic [2:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic z, input logic o, input logic i,
                       input int lat, input bit expect_done);
    exp_t e;
    @(negedge clk);
    alu_ctl = ctl;
    op_a    = a;
    op_b    = b;
    start   = 1'b1;
    if (expect_done) begin
      e.result = r;
      e.zero   = z;
      e.ovf    = o;
      e.ill    = i;
      e.cyc    = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_result"},   result,   0);
    check({tag, "_zero"},     zero,     1);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_illegal"},  illegal,  0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc,      e.cyc);
          check("result",     result,   e.result);
          check("zero",       zero,     e.zero);
          check("overflow",   overflow, e.ovf);
          check("illegal",    illegal,  e.ill);
        end
      end
    end
  end

  initial begin
    int n0;
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    start   = 1'b0;
    alu_ctl = ALU_AND;
    op_a    = '0;
    op_b    = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Add with signed overflow.
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0, 1, 1);
    idle();
    drain();

    // Back-to-back: sub to zero, then both slt orderings.
    issue(ALU_SUB, 32'd5, 32'd5, 32'd0, 1, 0, 0, 1, 1);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 1, 1);
    issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 0, 0, 1, 1);
    idle();
    drain();

    // Logic ops and a subtract that overflows.
    issue(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0, 1, 1);
    issue(ALU_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0, 0, 0, 1, 1);
    issue(ALU_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 0, 1, 1);
    idle();
    drain();

    // Unsupported code.
    issue(3'b101, 32'h0000_1234, 32'h0000_0001, 32'd0, 1, 0, 1, 1, 1);
    issue(3'b100, 32'h0000_0055, 32'h0000_0001, 32'd0, 1, 0, 1, 1, 1);
    idle();
    drain();

`ifdef ALU_MUL_EN
    // Multiply with non-zero high half; a start mid-operation is ignored.
    issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1, 1, 0, W + 1, 1);
    n0 = cyc;
    idle();
    check("mul_busy_early", busy, 1);
    while (cyc < n0 + 4) @(negedge clk);
    issue(ALU_ADD, 32'd9, 32'd9, 32'd0, 0, 0, 0, 1, 0);
    check("mul_busy_at_ignored_start", busy, 1);
    idle();
    drain();
    check("mul_busy_after_done", busy, 0);

    // Leave a non-reset result, then abort a multiply with rst.
    issue(ALU_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 1, 1);
    idle();
    drain();
    issue(ALU_MUL, 32'd3, 32'd7, 32'd0, 0, 0, 0, 0, 0);
    n0 = cyc;
    idle();
    while (cyc < n0 + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (W + 8) @(negedge clk);

    // Fresh multiply after the abort.
    issue(ALU_MUL, 32'd3, 32'd7, 32'd21, 0, 0, 0, W + 1, 1);
    idle();
    drain();
`else
    // Without the multiplier, code 011 is a one-cycle illegal op.
    issue(ALU_MUL, 32'd3, 32'd7, 32'd0, 1, 0, 1, 1, 1);
    idle();
    check("nomul_busy", busy, 0);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
